// File: rtl/clk_div_cfg_ctrl_if.sv
// Request and divider-control bundle between a ratio requester and clk_div_cfg_ctrl.
// The master drives requests and the divided-clock feedback; the slave is the controller.
`timescale 1ns/1ps
interface clk_div_cfg_ctrl_if #(
    parameter int RATIO_WIDTH = 5
);
    logic                   req_valid;
    logic [RATIO_WIDTH-1:0] req_ratio;
    logic                   req_ready;
    logic                   div_clk;
    logic                   clk_en;
    logic [RATIO_WIDTH-1:0] div_ratio;
    logic                   bypass;
    logic                   busy;
    logic                   done;
    logic                   timeout;

    modport master (
        output req_valid, req_ratio, div_clk,
        input  req_ready, clk_en, div_ratio, bypass, busy, done, timeout
    );

    modport slave (
        input  req_valid, req_ratio, div_clk,
        output req_ready, clk_en, div_ratio, bypass, busy, done, timeout
    );
endinterface

// File: rtl/clk_div_cfg_ctrl.sv
// Ratio-change sequencer for the integer clock divider: quiesce, reload, re-enable, settle.
// Define CLKDIV_CTRL_TIMEOUT_EN to add the WAIT_LOW watchdog and the sticky timeout flag.
`timescale 1ns/1ps
// state    | meaning
// IDLE     | ready for a ratio-change request
// WAIT_LOW | waiting for the divided clock to be low (or divider already stopped)
// GATE     | enable dropped, holding it low for STOP_CYCLES
// LOAD     | new ratio driven; park (ratio 0/1) or re-enable
// ENABLE   | enable raised, waiting SETTLE_CYCLES
// DONE     | one-cycle completion pulse
module clk_div_cfg_ctrl #(
    parameter int RATIO_WIDTH    = 5,
    parameter int DEFAULT_RATIO  = 2,
    parameter int STOP_CYCLES    = 2,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              ref_clk,
    input  logic              rst,
    clk_div_cfg_ctrl_if.slave bus
);

    localparam int CNT_MAX_SS = (STOP_CYCLES > SETTLE_CYCLES) ? STOP_CYCLES : SETTLE_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_SS > TIMEOUT_CYCLES) ? CNT_MAX_SS : TIMEOUT_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0]       STOP_TC    = CNT_W'(STOP_CYCLES - 1);
    localparam logic [CNT_W-1:0]       SETTLE_TC  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [RATIO_WIDTH-1:0] RATIO_DEF  = RATIO_WIDTH'(DEFAULT_RATIO);
    localparam logic [RATIO_WIDTH-1:0] RATIO_MIN  = RATIO_WIDTH'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LOW,
        S_GATE,
        S_LOAD,
        S_ENABLE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [RATIO_WIDTH-1:0] req_q, req_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   clk_en_q, clk_en_d;
    logic [RATIO_WIDTH-1:0] div_ratio_q, div_ratio_d;
    logic                   bypass_q, bypass_d;
    logic                   ready_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   req_park;
    logic                   cfg_match;

    // Requested config is already live: same ratio and the enable/bypass pair agrees with it.
    assign req_park  = (req_q < RATIO_MIN);
    assign cfg_match = (req_q == div_ratio_q) &&
                       (req_park ? (bypass_q && !clk_en_q) : (!bypass_q && clk_en_q));

`ifdef CLKDIV_CTRL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CYCLES - 1);
    logic timeout_q, timeout_d;
`endif

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            req_q       <= RATIO_DEF;
            cnt_q       <= '0;
            clk_en_q    <= 1'b0;
            div_ratio_q <= RATIO_DEF;
            bypass_q    <= (DEFAULT_RATIO < 2);
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            clk_en_q    <= clk_en_d;
            div_ratio_q <= div_ratio_d;
            bypass_q    <= bypass_d;
            ready_q     <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
        end
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        clk_en_d    = clk_en_q;
        div_ratio_d = div_ratio_q;
        bypass_d    = bypass_q;
`ifdef CLKDIV_CTRL_TIMEOUT_EN
        timeout_d   = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && ready_q) begin
                    req_d   = bus.req_ratio;
                    state_d = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW: begin
                if (cfg_match) begin
                    state_d = S_DONE;
                end else if (!bus.div_clk || !clk_en_q) begin
                    clk_en_d = 1'b0;
                    state_d  = S_GATE;
                end
`ifdef CLKDIV_CTRL_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == TIMEOUT_TC) begin
                        clk_en_d  = 1'b0;
                        timeout_d = 1'b1;
                        state_d   = S_GATE;
                    end
                end
`endif
            end
            S_GATE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == STOP_TC) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                div_ratio_d = req_q;
                if (req_park) begin
                    bypass_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    bypass_d = 1'b0;
                    clk_en_d = 1'b1;
                    state_d  = S_ENABLE;
                end
            end
            S_ENABLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == SETTLE_TC) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

`ifdef CLKDIV_CTRL_TIMEOUT_EN
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.req_ready = ready_q;
    assign bus.clk_en    = clk_en_q;
    assign bus.div_ratio = div_ratio_q;
    assign bus.bypass    = bypass_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
